// File: rtl/forwarding_scoreboard.sv
// Decode-stage operand forwarder with a long-latency pending scoreboard.
// Optional statistics counters are built when FORWARDING_COUNTERS_EN is defined.
module forwarding_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NSRC = 2,
  localparam int AW = $clog2(NREG)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NSRC-1:0]      reg_rden,
  input  logic [NSRC*AW-1:0]   reg_raddr,
  input  logic [NSRC*XLEN-1:0] reg_rdata,
  input  logic                 exec_wren,
  input  logic [AW-1:0]        exec_waddr,
  input  logic [XLEN-1:0]      exec_wdata,
  input  logic                 mem_wren,
  input  logic [AW-1:0]        mem_waddr,
  input  logic [XLEN-1:0]      mem_wdata,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_waddr,
  input  logic                 done_valid,
  input  logic [AW-1:0]        done_waddr,
  input  logic [XLEN-1:0]      done_wdata,
  input  logic                 flush,
  output logic [NSRC*XLEN-1:0] data,
  output logic                 stall,
  output logic [AW:0]          pending_count,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          fwd_count
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;
  logic [NSRC-1:0] src_haz;
  logic [NSRC-1:0] dhit;
  logic [NSRC-1:0] ehit;
  logic [NSRC-1:0] mhit;
  logic            waw;

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            done_here;

    assign ra = reg_raddr[g*AW +: AW];
    assign rd = reg_rdata[g*XLEN +: XLEN];
    assign done_here = done_valid && (done_waddr == ra);

    // x0 is hardwired, so it never matches a producer.
    assign dhit[g] = (ra != '0) && done_here && pending[ra];
    assign ehit[g] = (ra != '0) && exec_wren && (exec_waddr == ra);
    assign mhit[g] = (ra != '0) && mem_wren && (mem_waddr == ra);

    // A completing result on this cycle resolves the hazard.
    assign src_haz[g] = reg_rden[g] && pending[ra] && !done_here;

    assign data[g*XLEN +: XLEN] =
      !reg_rden[g] ? '0 :
      dhit[g]      ? done_wdata :
      ehit[g]      ? exec_wdata :
      mhit[g]      ? mem_wdata  :
                     rd;
  end

  assign waw = issue_valid && pending[issue_waddr] &&
               !(done_valid && (done_waddr == issue_waddr));

  assign stall = (|src_haz) || waw;

  // Next pending set: clear on completion, then set on issue; flush wipes all.
  always_comb begin
    pend_nxt = pending;
    if (flush) begin
      pend_nxt = '0;
    end else begin
      if (done_valid && pending[done_waddr])
        pend_nxt[done_waddr] = 1'b0;
      if (issue_valid && !stall && (issue_waddr != '0))
        pend_nxt[issue_waddr] = 1'b1;
    end
  end

  // Population count of the next pending set.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++)
      cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
  end

  // Scoreboard state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= '0;
      pending_count <= '0;
    end else begin
      pending       <= pend_nxt;
      pending_count <= cnt_nxt;
    end
  end

`ifdef FORWARDING_COUNTERS_EN
  logic [31:0] stall_q;
  logic [31:0] fwd_q;
  logic        fwd_any;

  assign fwd_any = |(reg_rden & (dhit | ehit | mhit));

  // Saturating statistics; flush leaves them untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
      fwd_q   <= '0;
    end else begin
      if (stall && (stall_q != 32'hFFFF_FFFF))
        stall_q <= stall_q + 32'd1;
      if (fwd_any && (fwd_q != 32'hFFFF_FFFF))
        fwd_q <= fwd_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign fwd_count    = fwd_q;
`else
  assign stall_cycles = '0;
  assign fwd_count    = '0;
`endif

endmodule
